pair_arbiter: RTL

PAIR_ARBITER -- requirements
Module: pair_arbiter

---
 rtl/pair_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/pair_arbiter.sv
// Two-requester arbiter feeding one registered output slot with a ready/valid handshake.
// A one-bit pointer alternates priority between A and B after each completed transfer.
module pair_arbiter #(
  parameter int size      = 8,
  parameter int sizetwo   = 6,
  parameter int out_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic [size-1:0]      in1,
  output logic                 ack_a,
  input  logic                 req_b,
  input  logic [sizetwo-1:0]   in2,
  output logic                 ack_b,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [out_width-1:0] out_data,
  output logic                 out_src,
  output logic [7:0]           xfer_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 ptr;
  logic                 grant_a;
  logic                 grant_b;
  logic [out_width-1:0] ext_a;
  logic [out_width-1:0] ext_b;

  // Fit each requester's data to the output bus: zero-extend or keep the low bits.
  generate
    if (size >= out_width) begin : g_a_trunc
      assign ext_a = in1[out_width-1:0];
    end else begin : g_a_ext
      assign ext_a = {{(out_width - size){1'b0}}, in1};
    end
    if (sizetwo >= out_width) begin : g_b_trunc
      assign ext_b = in2[out_width-1:0];
    end else begin : g_b_ext
      assign ext_b = {{(out_width - sizetwo){1'b0}}, in2};
    end
  endgenerate

  // A lone request wins outright; a tie goes to whoever the pointer favours.
  always_comb begin
    grant_a = req_a & (~req_b | ~ptr);
    grant_b = req_b & (~req_a | ptr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_a | grant_b) state_next = SEND;
      SEND: if (out_ready) state_next = IDLE;
    endcase
  end

  // Acks are gated by reset so requesters never see an acceptance during reset.
  always_comb begin
    ack_a     = (state == IDLE) & grant_a & ~reset;
    ack_b     = (state == IDLE) & grant_b & ~reset;
    out_valid = (state == SEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_src    <= 1'b0;
      ptr        <= 1'b0;
      xfer_count <= 8'd0;
    end else if ((state == IDLE) && (grant_a || grant_b)) begin
      out_data <= grant_a ? ext_a : ext_b;
      out_src  <= grant_b;
    end else if ((state == SEND) && out_ready) begin
      xfer_count <= xfer_count + 8'd1;
      ptr        <= ~out_src;
    end
  end

endmodule
